// File: rtl/zero_pkg.sv
// Shared definitions for the heap array shift engines: default sizes,
// the shift-down state encoding and the heap address helper.
package zero_pkg;

  localparam int default_element_width = 12;
  localparam int default_n_area        = 4;
  localparam int default_n_arrays      = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_CAP,
    S_RD,
    S_WR,
    S_CLR,
    S_SIZE,
    S_DONE
  } shift_down_state_t;

  // Element `index` of array `array` lives at n_area*array + index.
  function automatic int unsigned heap_addr(input int unsigned array,
                                            input int unsigned index,
                                            input int unsigned n_area);
    return n_area * array + index;
  endfunction

endpackage

// File: rtl/array_shift_down.sv
// Removes one element from a heap array, shifts the tail down and shrinks the length.
// Define SHIFT_DOWN_CLEAR_EN to zero the vacated top slot (adds one CLR cycle).
module array_shift_down
  import zero_pkg::*;
#(
  parameter int MemoryElementWidth = default_element_width,
  parameter int NArea              = default_n_area,
  parameter int NArrays            = default_n_arrays,
  localparam int AW = $clog2(NArea * NArrays),
  localparam int XW = $clog2(NArrays)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [XW-1:0]                 array,
  input  logic [MemoryElementWidth-1:0] pos,
  input  logic [MemoryElementWidth-1:0] sizeIn,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [MemoryElementWidth-1:0] value,
  output logic                          heapRe,
  output logic                          heapWe,
  output logic [AW-1:0]                 heapAddr,
  output logic [MemoryElementWidth-1:0] heapWData,
  input  logic [MemoryElementWidth-1:0] heapRData,
  output logic                          sizeWe,
  output logic [MemoryElementWidth-1:0] sizeOut
);

  localparam int MW = MemoryElementWidth;
  localparam logic [MW-1:0] ONE = MW'(1);
  localparam logic [MW-1:0] TWO = MW'(2);

`ifdef SHIFT_DOWN_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  shift_down_state_t state;
  logic [XW-1:0]     arr_reg;
  logic [MW-1:0]     idx_reg;
  logic [MW-1:0]     size_reg;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] a, input logic [MW-1:0] i);
    return AW'(heap_addr(32'(a), 32'(i), NArea));
  endfunction

  // Move writes forward the word read in the previous cycle straight from the heap.
  assign heapWData = (state == S_WR) ? heapRData : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      arr_reg  <= '0;
      idx_reg  <= '0;
      size_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      value    <= '0;
      heapRe   <= 1'b0;
      heapWe   <= 1'b0;
      heapAddr <= '0;
      sizeWe   <= 1'b0;
      sizeOut  <= '0;
    end else begin
      heapRe <= 1'b0;
      heapWe <= 1'b0;
      sizeWe <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (pos >= sizeIn || sizeIn > MW'(NArea)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error    <= 1'b0;
              arr_reg  <= array;
              idx_reg  <= pos;
              size_reg <= sizeIn;
              heapRe   <= 1'b1;
              heapAddr <= addr_of(array, pos);
              state    <= S_RD0;
            end
          end
        end
        S_RD0: state <= S_CAP;
        S_CAP: begin
          value <= heapRData;
          if (idx_reg + ONE < size_reg) begin
            heapRe   <= 1'b1;
            heapAddr <= addr_of(arr_reg, idx_reg + ONE);
            state    <= S_RD;
          end else if (ClearEn) begin
            heapWe   <= 1'b1;
            heapAddr <= addr_of(arr_reg, size_reg - ONE);
            state    <= S_CLR;
          end else begin
            sizeWe  <= 1'b1;
            sizeOut <= size_reg - ONE;
            state   <= S_SIZE;
          end
        end
        S_RD: begin
          heapWe   <= 1'b1;
          heapAddr <= addr_of(arr_reg, idx_reg);
          state    <= S_WR;
        end
        S_WR: begin
          idx_reg <= idx_reg + ONE;
          if (idx_reg + TWO < size_reg) begin
            heapRe   <= 1'b1;
            heapAddr <= addr_of(arr_reg, idx_reg + TWO);
            state    <= S_RD;
          end else if (ClearEn) begin
            heapWe   <= 1'b1;
            heapAddr <= addr_of(arr_reg, size_reg - ONE);
            state    <= S_CLR;
          end else begin
            sizeWe  <= 1'b1;
            sizeOut <= size_reg - ONE;
            state   <= S_SIZE;
          end
        end
        S_CLR: begin
          sizeWe  <= 1'b1;
          sizeOut <= size_reg - ONE;
          state   <= S_SIZE;
        end
        S_SIZE: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_shift_down.sv
// Scoreboard bench for array_shift_down with a behavioural heap; expectations
// follow SHIFT_DOWN_CLEAR_EN when it is defined for the build.
module tb_array_shift_down;

`ifdef SHIFT_DOWN_CLEAR_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic        clock;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [0:0]  sel_array = '0;
  logic [11:0] sel_pos = '0;
  logic [11:0] size_in = '0;
  logic        busy, done, error, heapRe, heapWe, sizeWe;
  logic [11:0] value, heapWData, sizeOut;
  logic [11:0] heapRData = '0;
  logic [2:0]  heapAddr;

  array_shift_down dut (
    .clock(clock), .reset(reset), .start(start), .array(sel_array), .pos(sel_pos),
    .sizeIn(size_in), .busy(busy), .done(done), .error(error), .value(value),
    .heapRe(heapRe), .heapWe(heapWe), .heapAddr(heapAddr), .heapWData(heapWData),
    .heapRData(heapRData), .sizeWe(sizeWe), .sizeOut(sizeOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [11:0] mem [8]     = '{12'd5, 12'd11, 12'd12, 12'd13, 12'd99, 12'd0, 12'd1, 12'd2};
  logic [11:0] exp_mem [8] = '{12'd5, 12'd11, 12'd12, 12'd13, 12'd99, 12'd0, 12'd1, 12'd2};

  always @(posedge clock) begin
    if (heapWe) mem[heapAddr] <= heapWData;
    if (heapRe) heapRData <= mem[heapAddr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [11:0] val;
    logic [11:0] szo;
    int          lat;
    int          we;
    int          sz;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int we_cnt = 0, sz_cnt = 0, ovl = 0;
  logic [11:0] sz_val = '0;

  // Monitor: sampled 1 time unit after each falling clock edge or reset assertion.
  always begin
    @(negedge clock or negedge reset);
    #1;
    if (!reset) begin
      check("reset_outputs", {busy, done, error, value, heapRe, heapWe, heapAddr,
                              heapWData, sizeWe, sizeOut}, '0);
      sb.delete();
      we_cnt = 0; sz_cnt = 0; ovl = 0;
    end else begin
      if (heapWe) we_cnt++;
      if (sizeWe) begin sz_cnt++; sz_val = sizeOut; end
      if (heapRe && heapWe) ovl++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("error", error, e.err);
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_at_done", busy, 1);
          check("heap_writes", we_cnt, e.we);
          check("size_writes", sz_cnt, e.sz);
          check("re_we_overlap", ovl, 0);
          if (!e.err) begin
            check("value", value, e.val);
            check("size_out", sz_val, e.szo);
          end
          $display("op done: err=%0d value=%0d sizeOut=%0d latency=%0d", error, value, sz_val,
                   cyc - e.start_cyc);
        end
        we_cnt = 0; sz_cnt = 0; ovl = 0;
      end else if (sb.size() != 0 && cyc - sb[0].start_cyc > 60) begin
        check("done_timeout", done, 1);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [127:0] pack_dut();
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = mem[i];
    return r;
  endfunction

  function automatic logic [127:0] pack_exp();
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = exp_mem[i];
    return r;
  endfunction

  task automatic run_op(input int a, input int p, input int s, input bit double_start);
    exp_t x;
    int m;
    x.err = (p >= s) || (s > 4);
    x.val = '0;
    x.szo = '0;
    if (x.err) begin
      x.lat = 1; x.we = 0; x.sz = 0;
    end else begin
      m = s - 1 - p;
      x.lat = 4 + 2 * m + C;
      x.we  = m + C;
      x.sz  = 1;
      x.val = exp_mem[4*a + p];
      x.szo = 12'(s - 1);
      for (int i = p; i < s - 1; i++) exp_mem[4*a + i] = exp_mem[4*a + i + 1];
      if (C == 1) exp_mem[4*a + s - 1] = '0;
    end
    @(negedge clock);
    x.start_cyc = cyc;
    sb.push_back(x);
    sel_array = 1'(a); sel_pos = 12'(p); size_in = 12'(s); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (double_start) begin
      @(negedge clock);
      sel_pos = 12'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("heap", pack_dut(), pack_exp());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;
    run_op(1, 0, 4, 1'b0);   // remove head, three moves
    run_op(0, 3, 4, 1'b0);   // remove last element, no moves
    run_op(1, 3, 3, 1'b0);   // pos == size: rejected
    run_op(1, 0, 0, 1'b0);   // size 0: rejected
    run_op(0, 1, 5, 1'b0);   // size above area: rejected
    run_op(0, 0, 1, 1'b0);   // array becomes empty
    run_op(1, 1, 3, 1'b1);   // second start while busy is ignored

    // Abort a three-move removal at its first WR cycle.
    @(negedge clock);
    sel_array = 1'b0; sel_pos = 12'd0; size_in = 12'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 30 && !heapWe; i++) @(negedge clock);
    check("reached_wr", heapWe, 1);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("heap_after_abort", pack_dut(), pack_exp());

    run_op(0, 2, 4, 1'b0);   // normal operation after reset
    repeat (10) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
